// File: rtl/mem_bridge_pkg.sv
// Shared types and defaults for the SRAM / memory-mapped I/O bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_bridge_tristate_dq.sv
// Registered output-enable and drive data for the bidirectional SRAM data bus.
module tristate_dq (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        oe_d,
  input  logic [15:0] dout_d,
  inout  wire  [15:0] dq,
  output logic [15:0] din
);

  logic        oe_q;
  logic [15:0] dout_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      oe_q   <= 1'b0;
      dout_q <= 16'h0000;
    end else begin
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign dq  = oe_q ? dout_q : 16'bz;
  assign din = dq;

endmodule

// File: rtl/mem_bridge.sv
// Bridges level-held CPU read/write requests onto an async SRAM, with one
// address decoded as memory-mapped I/O (switches in, hex display out).
//
// state      | meaning
// S_IDLE     | waiting for Mem_OE / Mem_WE; latches MAR/MDR on acceptance
// S_READ     | CE_N/OE_N low for RD_WAIT cycles, data captured on last cycle
// S_WR_SETUP | CE_N low, DQ driven, one cycle before the write strobe
// S_WR_PULSE | WE_N low for WR_PULSE cycles
// S_WR_HOLD  | DQ held one cycle after the write strobe
// S_DONE     | Mem_ready on first cycle; waits for requests to drop
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          RD_WAIT  = 2,
  parameter int          WR_PULSE = 2,
  parameter logic [15:0] IO_ADDR  = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_ready,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WR_PULSE - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] hex_q, hex_d;
  logic        ready_q, ready_d;
  logic        bl_n_q;
  logic        drive_d;
  logic [15:0] dq_in;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0000;
      mdr_q   <= 16'h0000;
      data_q  <= 16'h0000;
      hex_q   <= 16'h0000;
      ready_q <= 1'b0;
      bl_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      data_q  <= data_d;
      hex_q   <= hex_d;
      ready_q <= ready_d;
      bl_n_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    data_d  = data_q;
    hex_d   = hex_q;
    unique case (state_q)
      S_IDLE: begin
        if (Mem_WE || Mem_OE) begin
          addr_d = MAR;
          mdr_d  = MDR;
          if (MAR == IO_ADDR) begin
            state_d = S_DONE;
            if (Mem_WE) hex_d  = MDR;
            else        data_d = Switches;
          end else if (Mem_WE) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          data_d  = dq_in;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 3'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE: begin
        if (!Mem_OE && !Mem_WE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulse only on entry to DONE so a held request completes once.
  assign ready_d = (state_d == S_DONE) && (state_q != S_DONE);
  assign drive_d = !Reset && ((state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                              (state_d == S_WR_HOLD));

  tristate_dq u_dq (
    .Clk    (Clk),
    .Reset  (Reset),
    .oe_d   (drive_d),
    .dout_d (mdr_d),
    .dq     (SRAM_DQ),
    .din    (dq_in)
  );

  assign SRAM_CE_N   = !((state_q == S_READ) || (state_q == S_WR_SETUP) ||
                         (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD));
  assign SRAM_OE_N   = (state_q != S_READ);
  assign SRAM_WE_N   = (state_q != S_WR_PULSE);
  assign SRAM_UB_N   = bl_n_q;
  assign SRAM_LB_N   = bl_n_q;
  assign SRAM_ADDR   = {4'h0, addr_q};
  assign Data_to_CPU = data_q;
  assign HEX_Data    = hex_q;
  assign Mem_ready   = ready_q;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2: SRAM read access cycles, from OE_N low to data capture, range 1..7.
REQ-002 SHALL have parameter WR_PULSE, default 2: cycles SRAM_WE_N is held low, range 1..7.
REQ-003 SHALL have parameter IO_ADDR, default 16'hFFFF: memory-mapped I/O address.
REQ-004 SHALL have port Clk  in  1  system clock; all state changes occur on its rising edge.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port Mem_OE  in  1  read request from the control unit, active-high, level-held.
REQ-007 SHALL have port Mem_WE  in  1  write request from the control unit, active-high, level-held.
REQ-008 SHALL have port MAR  in  16  request address.
REQ-009 SHALL have port MDR  in  16  write data.
REQ-010 SHALL have port Switches  in  16  board switch value, returned on I/O reads.
REQ-011 SHALL have port Data_to_CPU  out  16  registered read data.
REQ-012 SHALL have port Mem_ready  out  1  one-cycle completion pulse.
REQ-013 SHALL have port HEX_Data  out  16  hex-display register, written by I/O writes.
REQ-014 SHALL have port SRAM_ADDR  out  20  SRAM address, equal to {4'h0, latched address}.
REQ-015 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-016 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

Function
REQ-017 SHALL implement states IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-018 SHALL, in IDLE, latch MAR and MDR and accept a request when Mem_OE or Mem_WE is high; if both are high, Mem_WE SHALL win.
REQ-019 SHALL, for an accepted request whose address equals IO_ADDR, perform no SRAM cycle and go directly to DONE.
- I/O read: capture Switches into Data_to_CPU.
- I/O write: load the latched MDR into HEX_Data.
REQ-020 SHALL, for an SRAM read, enter READ and drive SRAM_CE_N=0 and SRAM_OE_N=0 for RD_WAIT cycles; on the last READ cycle it SHALL capture SRAM_DQ into Data_to_CPU and go to DONE.
REQ-021 SHALL, for an SRAM write, step WR_SETUP (1 cycle) -> WR_PULSE (WR_PULSE cycles) -> WR_HOLD (1 cycle) -> DONE.
- SRAM_CE_N=0 in all three states.
- SRAM_WE_N=0 only in WR_PULSE.
- SRAM_DQ driven with the latched MDR in all three states.
REQ-022 SHALL tri-state SRAM_DQ in every state other than WR_SETUP, WR_PULSE and WR_HOLD.
REQ-023 SHALL assert Mem_ready for exactly the first cycle in DONE.
REQ-024 SHALL stay in DONE until Mem_OE and Mem_WE are both low, then return to IDLE; a held request SHALL never complete twice.
REQ-025 SHALL hold SRAM_ADDR stable for the whole access, ignoring MAR changes after acceptance.
REQ-026 SHALL hold SRAM_UB_N=0 and SRAM_LB_N=0 at all times outside reset.
REQ-027 SHALL hold Data_to_CPU and HEX_Data between updates.
REQ-028 SHALL give these cycle counts from the acceptance edge to the Mem_ready cycle:
- SRAM read: RD_WAIT+1.
- SRAM write: WR_PULSE+3.
- I/O access: 1.

Reset
REQ-029 SHALL, on Reset, enter IDLE on the next edge, including in the middle of an access, and abandon any in-flight access.
REQ-030 SHALL, on Reset, drive:
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N = 1.
- SRAM_DQ = Z.
- Mem_ready = 0.
- Data_to_CPU = 16'h0000.
- HEX_Data = 16'h0000.
- Latched address = 16'h0000.
REQ-031 SHALL ignore Mem_OE and Mem_WE in any cycle where Reset is high.

Structure
REQ-032 SHALL place the state enum and the IO_ADDR default in the shared package mem_bridge_pkg.
REQ-033 SHALL instantiate one sub-module, tristate_dq, which registers the output-enable and drive data for SRAM_DQ and returns the bus input.
REQ-034 SHALL use a single 3-bit wait counter shared by READ and WR_PULSE.

Verification
REQ-035 SHALL cover SRAM read: preload SRAM model at 0x0010 = 16'h1234; Mem_OE=1, MAR=16'h0010 -> OE_N low for 2 cycles, Mem_ready on cycle 3, Data_to_CPU=16'h1234.
REQ-036 SHALL cover SRAM write: Mem_WE=1, MAR=16'h0020, MDR=16'hBEEF -> WE_N low for exactly 2 cycles with DQ=16'hBEEF stable one cycle either side, Mem_ready on cycle 5, model holds 16'hBEEF at 0x0020.
REQ-037 SHALL cover I/O: read with MAR=16'hFFFF, Switches=16'h00A5 -> Data_to_CPU=16'h00A5 after 1 cycle, SRAM_CE_N stays 1; write with MDR=16'h0042 -> HEX_Data=16'h0042.
REQ-038 SHALL cover simultaneous requests and hold: Mem_OE=Mem_WE=1 -> write cycle performed; requests held high 10 extra cycles -> exactly one Mem_ready pulse.
REQ-039 SHALL cover reset mid-write: Reset asserted in WR_PULSE -> next cycle WE_N=1, DQ=Z, HEX_Data=0, state IDLE.
